// File: rtl/cmd_ram_pkg.sv
// Shared definitions for the command-driven RAM controller.
// Contents: frame opcode constants, FSM state encoding, and a small max() helper
// that sizes the frame payload.
package cmd_ram_pkg;

    // Frame opcodes carried in the two MSBs of din
    localparam logic [1:0] OP_SET_WR = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SET_RD = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    // IDLE accepts frames; HOLD presents read data until the consumer takes it
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sp_ram_array.sv
// Single-port word storage with write enable and registered read port (block-RAM friendly).
// Ports: clk; i_we/i_re enables; i_addr shared address; i_wdat write word; o_rdat registered read word.
// o_rdat updates only on a read enable, so it holds its value between reads. Contents are not reset.
module sp_ram_array #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdat,
    output logic [DATA_W-1:0] o_rdat
);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];
    logic [DATA_W-1:0] r_rdat;

    // The caller only asserts i_we/i_re for addresses below MEM_DEPTH
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdat;
        end
        if (i_re) begin
            r_rdat <= r_mem[i_addr];
        end
    end

    assign o_rdat = r_rdat;

endmodule

// File: rtl/cmd_ram_ctrl.sv
// Command-driven RAM: decodes 2-bit opcode frames into pointer set / write / read operations.
// Ports: clk, rst_n (sync, active-low); din/rx_valid/rx_ready frame input; dout/tx_valid/tx_ready
//        read-data output; err is a sticky out-of-range flag. READ data appears one edge after acceptance.
module cmd_ram_ctrl
    import cmd_ram_pkg::*;
#(
    parameter int  DATA_W    = 8,
    parameter int  ADDR_W    = 8,
    parameter int  MEM_DEPTH = 256,
    parameter int  AUTO_INC  = 1,
    localparam int PAY_W     = max_int(ADDR_W, DATA_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PAY_W+1:0]   din,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic [DATA_W-1:0]  dout,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               err
);

    // One extra bit so MEM_DEPTH == 2**ADDR_W is representable in the range compare
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(MEM_DEPTH - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic              r_tx_valid;
    logic              r_rx_ready;
    logic              r_err;
    // Forces dout to zero after reset and after an out-of-range read, since the
    // RAM output register itself is never reset
    logic              r_dout_clr;

    logic [1:0]        w_op;
    logic [PAY_W-1:0]  w_pay;
    logic              w_acc;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_we;
    logic              w_re;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_ram_rdat;

    function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
        return (p == LAST_L) ? '0 : p + ADDR_W'(1);
    endfunction

    assign w_op    = din[PAY_W+1:PAY_W];
    assign w_pay   = din[PAY_W-1:0];
    assign w_acc   = rx_valid && (r_state == IDLE);
    assign w_wr_ok = ({1'b0, r_wr_ptr} < DEPTH_L);
    assign w_rd_ok = ({1'b0, r_rd_ptr} < DEPTH_L);
    assign w_we    = w_acc && (w_op == OP_WRITE) && w_wr_ok;
    assign w_re    = w_acc && (w_op == OP_READ)  && w_rd_ok;
    // Single port: the opcode decides which pointer addresses the array
    assign w_addr  = (w_op == OP_WRITE) ? r_wr_ptr : r_rd_ptr;

    sp_ram_array #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk    (clk),
        .i_we   (w_we),
        .i_re   (w_re),
        .i_addr (w_addr),
        .i_wdat (w_pay[DATA_W-1:0]),
        .o_rdat (w_ram_rdat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_tx_valid <= 1'b0;
            r_rx_ready <= 1'b1;
            r_err      <= 1'b0;
            r_dout_clr <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        case (w_op)
                            OP_SET_WR: r_wr_ptr <= w_pay[ADDR_W-1:0];
                            OP_WRITE: begin
                                if (!w_wr_ok) begin
                                    r_err <= 1'b1;
                                end else if (AUTO_INC != 0) begin
                                    r_wr_ptr <= ptr_next(r_wr_ptr);
                                end
                            end
                            OP_SET_RD: r_rd_ptr <= w_pay[ADDR_W-1:0];
                            default: begin // OP_READ
                                r_state    <= HOLD;
                                r_tx_valid <= 1'b1;
                                r_rx_ready <= 1'b0;
                                if (!w_rd_ok) begin
                                    r_dout_clr <= 1'b1;
                                    r_err      <= 1'b1;
                                end else begin
                                    r_dout_clr <= 1'b0;
                                    if (AUTO_INC != 0) begin
                                        r_rd_ptr <= ptr_next(r_rd_ptr);
                                    end
                                end
                            end
                        endcase
                    end
                end
                HOLD: begin
                    if (tx_ready) begin
                        r_state    <= IDLE;
                        r_tx_valid <= 1'b0;
                        r_rx_ready <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rx_ready = r_rx_ready;
    assign tx_valid = r_tx_valid;
    assign err      = r_err;
    assign dout     = r_dout_clr ? '0 : w_ram_rdat;

endmodule

// File: tb/tb_cmd_ram_ctrl.sv
// Testbench for cmd_ram_ctrl: three instances (default, MEM_DEPTH=200, AUTO_INC=0)
// share clock, reset, din and tx_ready; each has its own rx_valid. Expected read
// words are queued when a READ is issued and compared when the DUT presents data.
module tb_cmd_ram_ctrl;
    import cmd_ram_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [9:0] din;
    logic [2:0] rx_valid;
    logic [2:0] rx_ready;
    logic [2:0] tx_valid;
    logic [2:0] err;
    logic       tx_ready;
    logic [7:0] dout [3];

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [$];
    logic [7:0] hold_dat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cmd_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
        .dout(dout[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready), .err(err[0]));

    cmd_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(1)) dut_d200 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
        .dout(dout[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready), .err(err[1]));

    cmd_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(0)) dut_ni (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid[2]), .rx_ready(rx_ready[2]),
        .dout(dout[2]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready), .err(err[2]));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a frame, waits (bounded) for rx_ready, and returns #1 after the accepting edge
    task automatic send(input int idx, input logic [1:0] op, input logic [7:0] pay);
        int n;
        din = {op, pay};
        rx_valid[idx] = 1'b1;
        n = 0;
        while (!rx_ready[idx] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_ready", {7'd0, rx_ready[idx]}, 8'd1);
        @(posedge clk); #1;
        rx_valid[idx] = 1'b0;
    endtask

    // READ with tx_ready high: data one edge after acceptance, tx_valid for exactly one cycle
    task automatic do_read(input int idx, input logic [7:0] exp);
        logic [7:0] e;
        sb.push_back(exp);
        send(idx, OP_READ, 8'h00);
        chk("rd_vld", {7'd0, tx_valid[idx]}, 8'd1);
        chk("rd_rdy_low", {7'd0, rx_ready[idx]}, 8'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rd_dat", dout[idx], e);
        end
        @(posedge clk); #1;
        chk("rd_vld_drop", {7'd0, tx_valid[idx]}, 8'd0);
        chk("rd_rdy_back", {7'd0, rx_ready[idx]}, 8'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        din      = '0;
        rx_valid = '0;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_tx_valid", {7'd0, tx_valid[0]}, 8'd0);
        chk("rst_rx_ready", {7'd0, rx_ready[0]}, 8'd1);
        chk("rst_err", {7'd0, err[0]}, 8'd0);
        chk("rst_dout", dout[0], 8'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic write then read
        send(0, OP_SET_WR, 8'h10);
        send(0, OP_WRITE, 8'hA5);
        send(0, OP_SET_RD, 8'h10);
        do_read(0, 8'hA5);

        // Burst across the 0xFF -> 0x00 wrap
        send(0, OP_SET_WR, 8'hFE);
        send(0, OP_WRITE, 8'h11);
        send(0, OP_WRITE, 8'h22);
        send(0, OP_WRITE, 8'h33);
        send(0, OP_SET_RD, 8'hFE);
        do_read(0, 8'h11);
        do_read(0, 8'h22);
        do_read(0, 8'h33);

        // READ on the edge right after a WRITE to the same address
        send(0, OP_SET_WR, 8'h40);
        send(0, OP_SET_RD, 8'h40);
        send(0, OP_WRITE, 8'h9C);
        do_read(0, 8'h9C);

        // Back-pressure: HOLD with a WRITE frame waiting
        send(0, OP_SET_WR, 8'h80);
        send(0, OP_SET_RD, 8'h10);
        tx_ready = 1'b0;
        sb.push_back(8'hA5);
        send(0, OP_READ, 8'h00);
        hold_dat = sb.pop_front();
        chk("bp_vld", {7'd0, tx_valid[0]}, 8'd1);
        chk("bp_dat", dout[0], hold_dat);
        din = {OP_WRITE, 8'hE1};
        rx_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_vld", {7'd0, tx_valid[0]}, 8'd1);
            chk("bp_hold_rdy", {7'd0, rx_ready[0]}, 8'd0);
            chk("bp_hold_dat", dout[0], hold_dat);
        end
        tx_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_handoff_vld", {7'd0, tx_valid[0]}, 8'd0);
        chk("bp_handoff_rdy", {7'd0, rx_ready[0]}, 8'd1);
        @(posedge clk); #1;
        rx_valid[0] = 1'b0;
        send(0, OP_WRITE, 8'hE2);
        send(0, OP_SET_RD, 8'h80);
        do_read(0, 8'hE1);
        do_read(0, 8'hE2);
        chk("a_err_clear", {7'd0, err[0]}, 8'd0);

        // MEM_DEPTH = 200: out-of-range accesses
        chk("d200_err_init", {7'd0, err[1]}, 8'd0);
        send(1, OP_SET_WR, 8'h48);
        send(1, OP_WRITE, 8'h33);
        send(1, OP_SET_WR, 8'h00);
        send(1, OP_WRITE, 8'h44);
        send(1, OP_SET_WR, 8'hC8);
        send(1, OP_WRITE, 8'h5A);
        chk("d200_err_wr", {7'd0, err[1]}, 8'd1);
        send(1, OP_SET_RD, 8'h48);
        do_read(1, 8'h33);
        send(1, OP_SET_RD, 8'h00);
        do_read(1, 8'h44);
        send(1, OP_SET_RD, 8'hC8);
        do_read(1, 8'h00);
        do_read(1, 8'h00);
        chk("d200_err_rd", {7'd0, err[1]}, 8'd1);
        // Increment wraps at MEM_DEPTH-1
        send(1, OP_SET_WR, 8'hC7);
        send(1, OP_WRITE, 8'h71);
        send(1, OP_WRITE, 8'h72);
        send(1, OP_SET_RD, 8'hC7);
        do_read(1, 8'h71);
        do_read(1, 8'h72);
        chk("d200_err_sticky", {7'd0, err[1]}, 8'd1);

        // AUTO_INC = 0: pointers stay put
        send(2, OP_SET_WR, 8'h05);
        send(2, OP_WRITE, 8'h77);
        send(2, OP_WRITE, 8'h78);
        send(2, OP_SET_RD, 8'h05);
        do_read(2, 8'h78);
        do_read(2, 8'h78);
        do_read(2, 8'h78);

        // Reset while in HOLD
        send(1, OP_SET_RD, 8'h48);
        tx_ready = 1'b0;
        sb.push_back(8'h33);
        send(1, OP_READ, 8'h00);
        hold_dat = sb.pop_front();
        chk("rh_pre_dat", dout[1], hold_dat);
        chk("rh_pre_vld", {7'd0, tx_valid[1]}, 8'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rh_vld", {7'd0, tx_valid[1]}, 8'd0);
        chk("rh_rdy", {7'd0, rx_ready[1]}, 8'd1);
        chk("rh_err", {7'd0, err[1]}, 8'd0);
        chk("rh_dout", dout[1], 8'h00);
        tx_ready = 1'b1;
        @(posedge clk); #1;
        // Both pointers back at 0: write then read without setting pointers
        send(1, OP_WRITE, 8'h3C);
        do_read(1, 8'h3C);

        chk("sb_empty", 8'(sb.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
